ce_monitor: RTL and testbench
=============================

# ce_monitor

Checker for the Vector-06C clock-enable bundle, running in the `clk24` domain. It receives the clock-enable and phase strobes from the clock generator: `ce12`, `ce6`, `ce3`, `ce3v`, `video_slice`, `ce1m5` and `pipe_ab`. It locks a local 64-phase model to them, checks every cycle against the fixed cadence, and reports lock, phase, sticky error bits, an error count and stall. It drives the board status LEDs and the debug register file.

## Interface
- `HOLDOFF`, 16: cycles spent in FAULT before re-acquiring.
- `ACQ_TIMEOUT`, 255: cycles in ACQUIRE without a `pipe_ab` rising edge before `stall` is raised.
- `ERR_W`, 8: width of the error counter.
- `clk24` in 1: 24 MHz system clock. One clock only.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce12`, `ce6`, `ce3`, `ce3v`, `video_slice`, `ce1m5`, `pipe_ab` in 1 each: observed strobes, registered at the source in `clk24`.
- `clr_err` in 1: single-cycle clear of `err_mask` and `err_cnt`.
- `locked` out 1: model is in lock.
- `phase` out 6: model phase p of the current input sample. Valid while `locked`.
- `err_mask` out 7: sticky mismatch bits, one per strobe:
  - [0] `ce12`, [1] `ce6`, [2] `ce3`, [3] `ce3v`
  - [4] `video_slice`, [5] `ce1m5`, [6] `pipe_ab`
- `err_cnt` out ERR_W: saturating count of LOCKED→FAULT events.
- `stall` out 1: no `pipe_ab` rising edge seen within the timeout.

## Operation
- Expected values at phase p (6-bit):
  - `ce12` = p[0]
  - `ce6` = p[1]&p[0]
  - `ce3` = (p[2:0]==5)
  - `ce3v` = (p[2:0]==6)
  - `video_slice` = !p[2]
  - `ce1m5` = (p[3:0]==13)
  - `pipe_ab` = p[5]
- Edge detection: `pipe_ab_d` holds `pipe_ab` delayed by one cycle. A rise is `pipe_ab & !pipe_ab_d`.
- **ACQUIRE** (reset state)
  - Wait for a `pipe_ab` rise. On the rise, the current sample is taken as p=32; set p to 33 for the next cycle and go to LOCKED.
  - A timeout counter counts cycles spent in ACQUIRE. When it reaches ACQ_TIMEOUT, set `stall`=1 and hold the counter.
  - `stall` clears on the next `pipe_ab` rise.
- **LOCKED**
  - Every cycle: compute mismatch = observed XOR expected(p) as 7 bits, then increment p (mod 64).
  - Mismatch ≠ 0: OR the mismatch into `err_mask`, increment `err_cnt` with saturation at all-ones, go to FAULT.
- **FAULT**
  - Count HOLDOFF cycles, then go to ACQUIRE.
  - No comparisons are made and `err_mask` is not updated.
- `clr_err` in the same cycle as a new mismatch: clear first, then apply the new event. Result: `err_mask` = the new mismatch bits, `err_cnt` = 1.
- `clr_err` in any state does not change the state machine.

## Timing
- Reset values:
  - state=ACQUIRE
  - `locked`=0, `phase`=0, `err_mask`=0, `err_cnt`=0, `stall`=0
  - timeout counter=0, holdoff counter=0, `pipe_ab_d`=0
- All outputs are registered.
- `locked` rises one cycle after the sample that carries the `pipe_ab` rise.
- `phase` reads 33 on the first cycle that `locked`=1, and increments every cycle after that.
- Mismatch sampled in cycle n: in cycle n+1, `locked`=0 and `err_mask`/`err_cnt` show the update.
- After FAULT entry at n+1, ACQUIRE is re-entered at n+1+HOLDOFF.
- Worst-case relock from ACQUIRE is 64 cycles plus 1 cycle of output latency.
- Asynchronous reset asserted mid-lock: all state returns to reset values immediately. No error is counted for the interrupted lock.
- The comparison path is combinational from the inputs into registers within one `clk24` cycle. No extra input pipeline.

## Structure
- Shared package `ce_pkg` holds:
  - state enum: ACQUIRE, LOCKED, FAULT
  - the 7 err bit index constants
  - function `ce_expect(p)` returning the 7-bit expected vector
- The generator's assertions and the bench model also use `ce_expect`.
- One sub-module is natural: `ce_pattern`, a combinational wrapper of `ce_expect`.
- The state machine and counters stay in `ce_monitor`.

## Test plan
- Correct generator model starting 3 cycles after reset release:
  - `locked`=1 one cycle after the first `pipe_ab` rise, with `phase`=33.
  - Over 1000 cycles, `err_mask` stays 0 and `err_cnt` stays 0.
- Force `ce3`=0 for one cycle at p=5 while locked:
  - Next cycle: `err_mask`=7'h04, `err_cnt`=1, `locked`=0.
  - `locked`=1 again within HOLDOFF+65 cycles.
- Drive all inputs to 0 from reset:
  - `stall`=1 after 255 cycles.
  - Then start the generator: `stall`=0 and `locked`=1 on the first rise.
- Assert `clr_err` in the same cycle as a `video_slice` mismatch, with prior mask 7'h01 and count 5:
  - Result: mask=7'h10, count=1.
- Inject 300 separate faults:
  - `err_cnt` saturates at 255 and does not wrap.
- Pulse `reset_n` low mid-lock for less than one clock:
  - All outputs return to 0 immediately.
  - Relock follows normally with `err_cnt`=0.

Source files
------------

// File: rtl/ce_pkg.sv
// Shared definitions for the clock-enable bundle: FSM states, strobe bit indices, cadence.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package ce_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } ce_state_e;

    localparam int CE_N         = 7;
    localparam int ERR_CE12     = 0;
    localparam int ERR_CE6      = 1;
    localparam int ERR_CE3      = 2;
    localparam int ERR_CE3V     = 3;
    localparam int ERR_VSLICE   = 4;
    localparam int ERR_CE1M5    = 5;
    localparam int ERR_PIPE_AB  = 6;

    // Phase assigned to the sample after the one carrying the pipe_ab rise (rise is p=32).
    localparam logic [5:0] LOCK_PHASE = 6'd33;

    function automatic logic [CE_N-1:0] ce_expect(input logic [5:0] p);
        logic [CE_N-1:0] e;
        e              = '0;
        e[ERR_CE12]    = p[0];
        e[ERR_CE6]     = p[1] & p[0];
        e[ERR_CE3]     = (p[2:0] == 3'd5);
        e[ERR_CE3V]    = (p[2:0] == 3'd6);
        e[ERR_VSLICE]  = ~p[2];
        e[ERR_CE1M5]   = (p[3:0] == 4'd13);
        e[ERR_PIPE_AB] = p[5];
        return e;
    endfunction

endpackage

// File: rtl/ce_monitor_if.sv
// Strobe bundle in, lock/error status out, between the clock generator side and the monitor.
// Latency: none (wiring only).
// Backpressure: none; strobes are observed every cycle.
interface ce_monitor_if #(
    parameter int ERR_W = 8
) ();
    logic             ce12;
    logic             ce6;
    logic             ce3;
    logic             ce3v;
    logic             video_slice;
    logic             ce1m5;
    logic             pipe_ab;
    logic             clr_err;
    logic             locked;
    logic [5:0]       phase;
    logic [6:0]       err_mask;
    logic [ERR_W-1:0] err_cnt;
    logic             stall;

    modport master (
        output ce12, ce6, ce3, ce3v, video_slice, ce1m5, pipe_ab, clr_err,
        input  locked, phase, err_mask, err_cnt, stall
    );

    modport slave (
        input  ce12, ce6, ce3, ce3v, video_slice, ce1m5, pipe_ab, clr_err,
        output locked, phase, err_mask, err_cnt, stall
    );
endinterface

// File: rtl/ce_pattern.sv
// Expected strobe vector for a model phase.
// Latency: combinational.
// Backpressure: none.
module ce_pattern
    import ce_pkg::*;
(
    input  logic [5:0]      phase_i,
    output logic [CE_N-1:0] exp_o
);
    assign exp_o = ce_expect(phase_i);
endmodule

// File: rtl/ce_monitor.sv
// Locks a 64-phase model to the clock-enable strobes and flags any deviation from the cadence.
// Latency: inputs compared combinationally, all status outputs registered (1 cycle).
// Backpressure: none; every clk24 sample is checked while locked.
module ce_monitor
    import ce_pkg::*;
#(
    parameter int HOLDOFF     = 16,
    parameter int ACQ_TIMEOUT = 255,
    parameter int ERR_W       = 8
) (
    input  logic         clk24,
    input  logic         reset_n,
    ce_monitor_if.slave  bus
);
    localparam int TMO_W  = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT + 1) : 1;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ACQ_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    ce_state_e         state_q, state_d;
    logic [5:0]        phase_q, phase_d;
    logic [CE_N-1:0]   mask_q, mask_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic              locked_q, locked_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pab_dly_q;

    logic [CE_N-1:0]   obs;
    logic [CE_N-1:0]   exp_vec;
    logic [CE_N-1:0]   mismatch;
    logic              rise;

    assign obs = {bus.pipe_ab, bus.ce1m5, bus.video_slice, bus.ce3v,
                  bus.ce3, bus.ce6, bus.ce12};

    ce_pattern u_pattern (
        .phase_i (phase_q),
        .exp_o   (exp_vec)
    );

    assign mismatch = obs ^ exp_vec;
    assign rise     = bus.pipe_ab & ~pab_dly_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tmo_d    = tmo_q;
        hold_d   = hold_q;
        stall_d  = stall_q;
        // Clear is applied first so a same-cycle fault lands on a fresh mask/count.
        mask_d   = bus.clr_err ? '0 : mask_q;
        cnt_d    = bus.clr_err ? '0 : cnt_q;

        unique case (state_q)
            ACQUIRE: begin
                if (rise) begin
                    state_d = LOCKED;
                    phase_d = LOCK_PHASE;
                    tmo_d   = '0;
                    stall_d = 1'b0;
                end else begin
                    if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_MAX) stall_d = 1'b1;
                end
            end
            LOCKED: begin
                phase_d = phase_q + 6'd1;
                if (|mismatch) begin
                    mask_d  = mask_d | mismatch;
                    cnt_d   = (&cnt_d) ? cnt_d : cnt_d + ERR_W'(1);
                    state_d = FAULT;
                    hold_d  = '0;
                end
            end
            FAULT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ACQUIRE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ACQUIRE;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ACQUIRE;
            phase_q   <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            locked_q  <= 1'b0;
            tmo_q     <= '0;
            hold_q    <= '0;
            pab_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            locked_q  <= locked_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            pab_dly_q <= bus.pipe_ab;
        end
    end

    assign bus.locked   = locked_q;
    assign bus.phase    = phase_q;
    assign bus.err_mask = mask_q;
    assign bus.err_cnt  = cnt_q;
    assign bus.stall    = stall_q;

endmodule

// File: tb/tb_ce_monitor.sv
// Bench for ce_monitor: randomized generator faults scored against a cycle-level behavioural model.
module tb_ce_monitor;
    localparam int HOLDOFF     = 16;
    localparam int ACQ_TIMEOUT = 255;
    localparam int ERR_W       = 8;
    localparam int CNT_MAX     = (1 << ERR_W) - 1;
    localparam int M_ACQ = 0, M_LOCK = 1, M_FAULT = 2;

    logic clk24   = 1'b0;
    logic reset_n = 1'b0;

    ce_monitor_if #(.ERR_W(ERR_W)) bus ();

    ce_monitor #(.HOLDOFF(HOLDOFF), .ACQ_TIMEOUT(ACQ_TIMEOUT), .ERR_W(ERR_W)) dut (
        .clk24   (clk24),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk24 = ~clk24;

    int n_cmp = 0;
    int n_err = 0;
    int gen_p = 0;
    bit gen_on = 1'b0;

    int         m_mode, m_phase, m_cnt, m_acq, m_left;
    logic [6:0] m_mask;
    bit         m_stall, m_pab_d;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cadence written from the phase arithmetic, independent of the design package.
    function automatic logic [6:0] gen_vec(input int p);
        logic [6:0] v;
        v[0] = (p % 2) == 1;
        v[1] = (p % 4) == 3;
        v[2] = (p % 8) == 5;
        v[3] = (p % 8) == 6;
        v[4] = (p % 8) < 4;
        v[5] = (p % 16) == 13;
        v[6] = p >= 32;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_ACQ; m_phase = 0; m_cnt = 0; m_acq = 0; m_left = 0;
        m_mask = '0; m_stall = 1'b0; m_pab_d = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] obs, input bit clr);
        bit         rise;
        logic [6:0] mm;
        rise    = obs[6] && !m_pab_d;
        m_pab_d = obs[6];
        if (clr) begin
            m_mask = '0;
            m_cnt  = 0;
        end
        if (m_mode == M_ACQ) begin
            if (rise) begin
                m_mode = M_LOCK; m_phase = 33; m_acq = 0; m_stall = 1'b0;
            end else begin
                m_acq++;
                if (m_acq >= ACQ_TIMEOUT) m_stall = 1'b1;
            end
        end else if (m_mode == M_LOCK) begin
            mm      = obs ^ gen_vec(m_phase);
            m_phase = (m_phase + 1) % 64;
            if (mm != 7'h00) begin
                m_mask = m_mask | mm;
                m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                m_mode = M_FAULT;
                m_left = HOLDOFF;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_mode = M_ACQ;
        end
    endtask

    task automatic drive_cycle(input logic [6:0] flip, input bit clr);
        logic [6:0] v;
        v = (gen_on ? gen_vec(gen_p) : 7'h00) ^ flip;
        {bus.pipe_ab, bus.ce1m5, bus.video_slice, bus.ce3v, bus.ce3, bus.ce6, bus.ce12} = v;
        bus.clr_err = clr;
        if (gen_on) gen_p = (gen_p + 1) % 64;
        @(posedge clk24);
        model_step(v, clr);
        @(negedge clk24);
        check("locked",   int'(bus.locked),   int'(m_mode == M_LOCK));
        check("stall",    int'(bus.stall),    int'(m_stall));
        check("err_mask", int'(bus.err_mask), int'(m_mask));
        check("err_cnt",  int'(bus.err_cnt),  m_cnt);
        if (m_mode == M_LOCK) check("phase", int'(bus.phase), m_phase);
    endtask

    task automatic do_reset();
        gen_on = 1'b0;
        {bus.pipe_ab, bus.ce1m5, bus.video_slice, bus.ce3v, bus.ce3, bus.ce6, bus.ce12} = 7'h00;
        bus.clr_err = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk24);
        @(negedge clk24);
        reset_n = 1'b1;
    endtask

    task automatic wait_lock(input int max_cyc);
        for (int i = 0; i < max_cyc && m_mode != M_LOCK; i++) drive_cycle(7'h00, 1'b0);
        check("relock", int'(bus.locked), 1);
    endtask

    task automatic sync_to(input int p);
        for (int i = 0; i < 64 && gen_p != p; i++) drive_cycle(7'h00, 1'b0);
    endtask

    task automatic run_to_first_rise();
        for (int i = 0; i < 40 && gen_p != 32; i++) drive_cycle(7'h00, 1'b0);
        check("pre_rise_locked", int'(bus.locked), 0);
        drive_cycle(7'h00, 1'b0);
        check("first_lock", int'(bus.locked), 1);
        check("first_phase", int'(bus.phase), 33);
        check("first_stall", int'(bus.stall), 0);
    endtask

    initial begin
        int k;
        do_reset();
        check("rst_locked", int'(bus.locked), 0);
        check("rst_phase",  int'(bus.phase), 0);
        check("rst_mask",   int'(bus.err_mask), 0);
        check("rst_cnt",    int'(bus.err_cnt), 0);
        check("rst_stall",  int'(bus.stall), 0);

        // Clean generator, starting three cycles after reset release.
        repeat (3) drive_cycle(7'h00, 1'b0);
        gen_p  = $urandom_range(0, 31);
        gen_on = 1'b1;
        run_to_first_rise();
        repeat (1000) drive_cycle(7'h00, 1'b0);
        check("clean_mask", int'(bus.err_mask), 0);
        check("clean_cnt",  int'(bus.err_cnt), 0);

        // ce3 dropped at p=5.
        sync_to(5);
        check("ce3_prelock", int'(bus.locked), 1);
        drive_cycle(7'h04, 1'b0);
        check("ce3_mask",   int'(bus.err_mask), 'h04);
        check("ce3_cnt",    int'(bus.err_cnt), 1);
        check("ce3_locked", int'(bus.locked), 0);
        k = 0;
        while (!bus.locked && k < 200) begin
            drive_cycle(7'h00, 1'b0);
            k++;
        end
        check("ce3_relock_in_budget", int'(k <= HOLDOFF + 65), 1);

        // Random single-strobe faults and clears.
        repeat (2000) begin
            logic [6:0] fl;
            fl = ($urandom_range(0, 49) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
            drive_cycle(fl, $urandom_range(0, 99) == 0);
        end
        repeat (100) drive_cycle(7'h00, 1'b0);

        // Clear coinciding with a video_slice fault.
        wait_lock(100);
        drive_cycle(7'h00, 1'b1);
        repeat (5) begin
            wait_lock(100);
            drive_cycle(7'h01, 1'b0);
        end
        wait_lock(100);
        check("clr_pre_mask", int'(bus.err_mask), 'h01);
        check("clr_pre_cnt",  int'(bus.err_cnt), 5);
        drive_cycle(7'h10, 1'b1);
        check("clr_mask", int'(bus.err_mask), 'h10);
        check("clr_cnt",  int'(bus.err_cnt), 1);

        // 300 faults: counter must saturate.
        for (int f = 0; f < 300; f++) begin
            wait_lock(100);
            repeat ($urandom_range(0, 20)) drive_cycle(7'h00, 1'b0);
            drive_cycle(7'(1 << $urandom_range(0, 6)), 1'b0);
        end
        check("sat_cnt", int'(bus.err_cnt), CNT_MAX);

        // Short reset pulse mid-lock, while pipe_ab is low.
        wait_lock(100);
        sync_to(10);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("pulse_locked", int'(bus.locked), 0);
        check("pulse_phase",  int'(bus.phase), 0);
        check("pulse_mask",   int'(bus.err_mask), 0);
        check("pulse_cnt",    int'(bus.err_cnt), 0);
        check("pulse_stall",  int'(bus.stall), 0);
        #1 reset_n = 1'b1;
        wait_lock(100);
        check("pulse_relock_cnt", int'(bus.err_cnt), 0);

        // Idle inputs from reset: stall after the timeout, cleared on first rise.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive_cycle(7'h00, 1'b0);
            if (i == ACQ_TIMEOUT - 2) check("stall_early", int'(bus.stall), 0);
            if (i == ACQ_TIMEOUT - 1) check("stall_set",   int'(bus.stall), 1);
        end
        gen_p  = $urandom_range(0, 31);
        gen_on = 1'b1;
        for (int i = 0; i < 40 && gen_p != 32; i++) drive_cycle(7'h00, 1'b0);
        check("stall_held", int'(bus.stall), 1);
        drive_cycle(7'h00, 1'b0);
        check("stall_clear",  int'(bus.stall), 0);
        check("stall_locked", int'(bus.locked), 1);
        check("stall_phase",  int'(bus.phase), 33);
        repeat (100) drive_cycle(7'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
